// File: rtl/frame_config_sequencer.sv
// frame_config_sequencer: column configuration controller.
// Collects an address word plus NUM_ROWS data words over valid/ready,
// presents them on FrameData and fires one FrameStrobe line with one
// cycle of setup before and one cycle of hold after the pulse.
// Optional build macro FRAME_CHECK_EN adds a trailing XOR check word
// that must match before the strobe is issued.
module frame_config_sequencer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NUM_ROWS        = 4,
  parameter int STROBE_CYCLES   = 1
) (
  input  logic                                CLK,
  input  logic                                resetn,
  input  logic [FrameBitsPerRow-1:0]          s_data,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic                                err_clr,
  output logic [NUM_ROWS*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]          FrameStrobe,
  output logic                                busy,
  output logic                                frame_err,
  output logic [15:0]                         frames_done
);

  localparam int DW = NUM_ROWS * FrameBitsPerRow;
  localparam int CW = $clog2(NUM_ROWS + 1);
  localparam int SW = $clog2(STROBE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [7:0]             r_index;
  logic [CW-1:0]          r_word_cnt;
  logic [SW-1:0]          r_strobe_cnt;
  logic [DW-1:0]          r_data;
  logic [MaxFramesPerCol-1:0] r_strobe;
  logic                   r_err;
  logic [15:0]            r_done;

  logic                   w_accept;
  logic                   w_sync_ok;
  logic                   w_index_ok;
  logic                   w_last_word;
  logic                   w_strobe_last;
  logic                   w_err_set;
  logic [MaxFramesPerCol-1:0] w_onehot;

`ifdef FRAME_CHECK_EN
  logic [FrameBitsPerRow-1:0] r_xor;
  assign s_ready = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_CHECK);
`else
  assign s_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
`endif

  assign w_accept      = s_valid & s_ready;
  assign w_sync_ok     = (s_data[31:24] == 8'hFA);
  assign w_index_ok    = (32'(r_index) < MaxFramesPerCol);
  assign w_last_word   = (r_word_cnt == CW'(NUM_ROWS - 1));
  assign w_strobe_last = (r_strobe_cnt == SW'(STROBE_CYCLES - 1));

  // Decode the latched frame index into the strobe pattern.
  genvar gi;
  generate
    for (gi = 0; gi < MaxFramesPerCol; gi++) begin : g_onehot
      assign w_onehot[gi] = (r_index == 8'(gi));
    end
  endgenerate

  assign FrameData   = r_data;
  assign FrameStrobe = r_strobe;
  assign busy        = (r_state != S_IDLE);
  assign frame_err   = r_err;
  assign frames_done = r_done;

  // State register.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic and error detection.
  always_comb begin
    w_state_next = r_state;
    w_err_set    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_sync_ok) w_state_next = S_LOAD;
          else           w_err_set    = 1'b1;
        end
      end
      S_LOAD: begin
        if (w_accept && w_last_word) begin
          if (!w_index_ok) begin
            // Out-of-range frame: data already consumed, skip the strobe.
            w_state_next = S_IDLE;
            w_err_set    = 1'b1;
          end else begin
`ifdef FRAME_CHECK_EN
            w_state_next = S_CHECK;
`else
            w_state_next = S_SETUP;
`endif
          end
        end
      end
`ifdef FRAME_CHECK_EN
      S_CHECK: begin
        if (w_accept) begin
          if (s_data == r_xor) begin
            w_state_next = S_SETUP;
          end else begin
            w_state_next = S_IDLE;
            w_err_set    = 1'b1;
          end
        end
      end
`endif
      S_SETUP:  w_state_next = S_STROBE;
      S_STROBE: if (w_strobe_last) w_state_next = S_HOLD;
      S_HOLD:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Latch the frame index and shift data words into the frame register.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_index    <= '0;
      r_word_cnt <= '0;
      r_data     <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_accept && w_sync_ok) begin
        r_index    <= s_data[7:0];
        r_word_cnt <= '0;
      end
      if ((r_state == S_LOAD) && w_accept) begin
        r_data     <= (r_data << FrameBitsPerRow) | DW'(s_data);
        r_word_cnt <= r_word_cnt + CW'(1);
      end
    end
  end

`ifdef FRAME_CHECK_EN
  // Running XOR of address and data words for the trailing check word.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_xor <= '0;
    end else if (w_accept && (r_state == S_IDLE)) begin
      r_xor <= s_data;
    end else if (w_accept && (r_state == S_LOAD)) begin
      r_xor <= r_xor ^ s_data;
    end
  end
`endif

  // Strobe width counter and registered strobe output.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_strobe_cnt <= '0;
      r_strobe     <= '0;
    end else begin
      if (r_state == S_SETUP)       r_strobe_cnt <= '0;
      else if (r_state == S_STROBE) r_strobe_cnt <= r_strobe_cnt + SW'(1);
      r_strobe <= (w_state_next == S_STROBE) ? w_onehot : '0;
    end
  end

  // Completed-frame counter and sticky error flag (set wins over clear).
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_done <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_HOLD) r_done <= r_done + 16'd1;
      if (w_err_set)         r_err  <= 1'b1;
      else if (err_clr)      r_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Testbench for frame_config_sequencer: random and directed frames,
// scoreboard queue of expected strobes checked by a negedge monitor.
module tb_frame_config_sequencer;

  localparam int NF = 20;
  localparam int FB = 32;
  localparam int NR = 4;
  localparam int SC = 3;
  localparam int DW = NR * FB;
`ifdef FRAME_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          resetn = 1'b0;
  logic [FB-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          err_clr = 1'b0;
  logic          s_ready;
  logic [DW-1:0] FrameData;
  logic [NF-1:0] FrameStrobe;
  logic          busy;
  logic          frame_err;
  logic [15:0]   frames_done;

  frame_config_sequencer #(
    .MaxFramesPerCol(NF), .FrameBitsPerRow(FB), .NUM_ROWS(NR), .STROBE_CYCLES(SC)
  ) dut (
    .CLK(CLK), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .err_clr(err_clr), .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy),
    .frame_err(frame_err), .frames_done(frames_done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [NF-1:0] strobe;
    logic [DW-1:0] data;
    logic [15:0]   done;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_done = '0;
  logic        model_err = 1'b0;
  int          last_hs = -100;
  int          idle_cyc = -100;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: each strobe pulse pops one expected frame and is checked for
  // line, data, latency from the last handshake, width, hold and idle.
  int            mon_w = 0;
  logic [NF-1:0] mon_prev = '0;
  logic          mon_hold = 1'b0;
  exp_t          cur = '0;
  always @(negedge CLK) begin
    if (!resetn) begin
      mon_w = 0; mon_prev = '0; mon_hold = 1'b0;
    end else begin
      if (FrameStrobe != '0 && mon_prev == '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 128'(FrameStrobe), 128'(0));
        end else begin
          cur = exp_q.pop_front();
          chk("strobe_line", 128'(FrameStrobe), 128'(cur.strobe));
          chk("strobe_data", 128'(FrameData), 128'(cur.data));
          // Strobe appears in the cycle after SETUP: one edge after the handshake edge.
          chk("strobe_latency", 128'(cyc - last_hs), 128'(1));
        end
        chk("strobe_ready_low", 128'(s_ready), 128'(0));
        mon_w = 1;
      end else if (FrameStrobe != '0) begin
        chk("strobe_stable", 128'(FrameStrobe), 128'(mon_prev));
        mon_w++;
      end else if (mon_prev != '0) begin
        chk("strobe_width", 128'(mon_w), 128'(SC));
        chk("hold_ready_low", 128'(s_ready), 128'(0));
        chk("hold_busy", 128'(busy), 128'(1));
        chk("hold_data", 128'(FrameData), 128'(cur.data));
        mon_hold = 1'b1;
      end else if (mon_hold) begin
        mon_hold = 1'b0;
        idle_cyc = cyc;
        chk("idle_ready", 128'(s_ready), 128'(1));
        chk("idle_frames_done", 128'(frames_done), 128'(cur.done));
      end
      mon_prev = FrameStrobe;
    end
  end

  task automatic send_word(input logic [31:0] w, input int gap);
    int t;
    s_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge CLK);
      s_data = $urandom;
    end
    @(negedge CLK);
    s_valid = 1'b1;
    s_data  = w;
    t = 0;
    while (!s_ready && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (!s_ready) begin
      chk("handshake_timeout", 128'(s_ready), 128'(1));
      s_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    last_hs = cyc;
    s_valid = 1'b0;
    s_data  = $urandom;
  endtask

  task automatic send_frame(input logic [31:0] addr, input logic [DW-1:0] data,
                            input logic bad_chk, input int maxgap, output int addr_hs);
    logic [31:0] x;
    logic [31:0] w;
    exp_t        e;
    $display("frame addr=%h data=%h bad_chk=%0d", addr, data, bad_chk);
    send_word(addr, int'($urandom_range(maxgap, 0)));
    addr_hs = last_hs;
    x = addr;
    if (addr[31:24] != 8'hFA) begin
      model_err = 1'b1;
      return;
    end
    for (int r = 0; r < NR; r++) begin
      w = data[DW-1-r*FB -: FB];
      x = x ^ w;
      send_word(w, int'($urandom_range(maxgap, 0)));
    end
    chk("load_data", 128'(FrameData), 128'(data));
    if (int'(addr[7:0]) >= NF) begin
      model_err = 1'b1;
      return;
    end
    if (CHK_EN) begin
      send_word(bad_chk ? (x ^ 32'h0000_0100) : x, int'($urandom_range(maxgap, 0)));
      if (bad_chk) begin
        model_err = 1'b1;
        return;
      end
    end
    e.strobe   = NF'(1) << addr[7:0];
    e.data     = data;
    model_done = model_done + 16'd1;
    e.done     = model_done;
    exp_q.push_back(e);
  endtask

  task automatic finish_frame();
    int t;
    t = 0;
    @(negedge CLK);
    while (busy && t < 60) begin
      @(negedge CLK);
      t++;
    end
    chk("idle_reached", 128'(busy), 128'(0));
    chk("frame_err", 128'(frame_err), 128'(model_err));
    chk("frames_done", 128'(frames_done), 128'(model_done));
  endtask

  task automatic clear_err();
    @(negedge CLK);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    model_err = 1'b0;
    chk("err_clr", 128'(frame_err), 128'(0));
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int r = 0; r < NR; r++) d[r*FB +: FB] = $urandom;
    return d;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hs_a;
    int hs_b;
    logic [31:0] addr;
    int t;

    // Reset state
    repeat (3) @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    chk("rst_framedata", 128'(FrameData), 128'(0));
    chk("rst_strobe", 128'(FrameStrobe), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err", 128'(frame_err), 128'(0));
    chk("rst_done", 128'(frames_done), 128'(0));
    chk("rst_ready", 128'(s_ready), 128'(1));

    // Basic frame to index 3
    send_frame(32'hFA000003, 128'h11111111_22222222_33333333_44444444, 1'b0, 0, hs_a);
    finish_frame();

    // Out-of-range index: words consumed, no strobe, error set
    send_frame(32'hFA000014, rand_data(), 1'b0, 1, hs_a);
    finish_frame();
    clear_err();

    // Bad sync while err_clr is high: set must win
    err_clr = 1'b1;
    send_word(32'h12000003, 0);
    err_clr = 1'b0;
    model_err = 1'b1;
    @(negedge CLK);
    chk("badsync_err", 128'(frame_err), 128'(1));
    chk("badsync_busy", 128'(busy), 128'(0));
    send_frame(32'hFA000001, rand_data(), 1'b0, 0, hs_a);
    finish_frame();
    clear_err();

    // Back-to-back frames: next address taken on first IDLE cycle after HOLD
    send_frame(32'hFA000007, rand_data(), 1'b0, 0, hs_a);
    send_frame(32'hFA000013, rand_data(), 1'b0, 0, hs_b);
    chk("b2b_accept_cycle", 128'(hs_b), 128'(idle_cyc + 1));
    finish_frame();

    // Back-to-back with random valid gaps, then a corrupted check word
    send_frame(32'hFA00000B, rand_data(), 1'b0, 3, hs_a);
    send_frame(32'hFA000000, rand_data(), 1'b0, 3, hs_a);
    finish_frame();
    send_frame(32'hFA000002, rand_data(), 1'b1, 2, hs_a);
    finish_frame();
    clear_err();

    // Randomized frames
    for (int n = 0; n < 12; n++) begin
      addr = {8'hFA, 16'($urandom), 8'($urandom_range(23, 0))};
      if ($urandom_range(7, 0) == 0) begin
        addr[31:24] = 8'($urandom);
        if (addr[31:24] == 8'hFA) addr[31:24] = 8'h00;
      end
      send_frame(addr, rand_data(), ($urandom_range(3, 0) == 0), 3, hs_a);
      finish_frame();
      if ($urandom_range(1, 0) == 1) clear_err();
    end

    // Asynchronous reset during STROBE
    send_frame(32'hFA000009, rand_data(), 1'b0, 0, hs_a);
    t = 0;
    while (FrameStrobe == '0 && t < 20) begin
      @(negedge CLK);
      t++;
    end
    chk("strobe_seen_before_reset", 128'(FrameStrobe != '0), 128'(1));
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_strobe", 128'(FrameStrobe), 128'(0));
    chk("async_rst_busy", 128'(busy), 128'(0));
    chk("async_rst_data", 128'(FrameData), 128'(0));
    chk("async_rst_done", 128'(frames_done), 128'(0));
    exp_q.delete();
    model_done = '0;
    model_err  = 1'b0;
    repeat (2) @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    chk("post_rst_ready", 128'(s_ready), 128'(1));
    send_frame(32'hFA000004, rand_data(), 1'b0, 2, hs_a);
    finish_frame();

    repeat (3) @(negedge CLK);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
